// File: rtl/io_pkg.sv
// io_pkg: shared widths, reset defaults and character type for the I/O unit
package io_pkg;
    localparam int CHAR_W_DEFAULT = 8;
    localparam logic FGO_RESET_DEFAULT = 1'b1;
    typedef logic [7:0] char_t;
endpackage

// File: rtl/io_out_channel.sv
// io_out_channel: OUTR/FGO printer channel with overrun detect (overrun port only with IO_ERROR_FLAGS_EN)
module io_out_channel import io_pkg::*; #(
    parameter int CHAR_W = CHAR_W_DEFAULT,
    parameter logic FGO_RESET = FGO_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_out,
    input  logic [CHAR_W-1:0] ac_low,
    input  logic              prn_ready,
    output logic [CHAR_W-1:0] outr,
    output logic              fgo,
    output logic              prn_valid
`ifdef IO_ERROR_FLAGS_EN
    ,
    output logic              overrun
`endif
);
    always_ff @(posedge clk) begin
        if (rst) begin
            outr      <= '0;
            fgo       <= FGO_RESET;
            prn_valid <= 1'b0;
        end else if (op_out & fgo) begin
            outr      <= ac_low;
            fgo       <= 1'b0;
            prn_valid <= 1'b1;
        end else if (prn_valid & prn_ready) begin
            prn_valid <= 1'b0;
            fgo       <= 1'b1;
        end
    end
`ifdef IO_ERROR_FLAGS_EN
    assign overrun = op_out & ~fgo;
`endif
endmodule

// File: rtl/io_unit.sv
// io_unit: Mano I/O unit (INPR/FGI input, OUTR/FGO output, IEN); IO_ERROR_FLAGS_EN enables sticky err_out
module io_unit import io_pkg::*; #(
    parameter int CHAR_W = CHAR_W_DEFAULT,
    parameter logic FGO_RESET = FGO_RESET_DEFAULT
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [CHAR_W-1:0] kbd_data_in,
    input  logic              kbd_valid_in,
    output logic              kbd_ready_out,
    output logic [CHAR_W-1:0] prn_data_out,
    output logic              prn_valid_out,
    input  logic              prn_ready_in,
    input  logic [CHAR_W-1:0] ac_low_in,
    output logic [CHAR_W-1:0] inpr_out,
    input  logic              op_inp_in,
    input  logic              op_out_in,
    input  logic              op_ski_in,
    input  logic              op_sko_in,
    input  logic              op_ion_in,
    input  logic              op_iof_in,
    input  logic              int_ack_in,
    output logic              skip_out,
    output logic              fgi_out,
    output logic              fgo_out,
    output logic              ien_out,
    output logic              irq_out,
    output logic              err_out
);
    logic [CHAR_W-1:0] inpr;
    logic fgi, ien, fgo, accept;
    assign accept = kbd_valid_in & ~fgi;
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            inpr <= '0;
            fgi  <= 1'b0;
            ien  <= 1'b0;
        end else begin
            inpr <= accept ? kbd_data_in : inpr;
            fgi  <= accept | (fgi & ~op_inp_in);
            ien  <= ~int_ack_in & ~op_iof_in & (op_ion_in | ien);
        end
    end
`ifdef IO_ERROR_FLAGS_EN
    logic overrun, err;
    always_ff @(posedge clk_in) begin
        err <= reset_in ? 1'b0 : err | overrun | (op_inp_in & ~fgi);
    end
    assign err_out = err;
`else
    assign err_out = 1'b0;
`endif
    io_out_channel #(.CHAR_W(CHAR_W), .FGO_RESET(FGO_RESET)) u_out (
        .clk       (clk_in),
        .rst       (reset_in),
        .op_out    (op_out_in),
        .ac_low    (ac_low_in),
        .prn_ready (prn_ready_in),
        .outr      (prn_data_out),
        .fgo       (fgo),
        .prn_valid (prn_valid_out)
`ifdef IO_ERROR_FLAGS_EN
        ,
        .overrun   (overrun)
`endif
    );
    assign inpr_out      = inpr;
    assign kbd_ready_out = ~fgi;
    assign fgi_out       = fgi;
    assign fgo_out       = fgo;
    assign ien_out       = ien;
    assign skip_out      = (op_ski_in & fgi) | (op_sko_in & fgo);
    assign irq_out       = ien & (fgi | fgo);
endmodule

// File: tb/tb_io_unit.sv
// tb_io_unit: scoreboard bench for io_unit with a behavioural model and printed-character check
module tb_io_unit;
    import io_pkg::*;
    logic clk = 1'b0;
    logic reset_in, kbd_valid_in, prn_ready_in;
    logic op_inp_in, op_out_in, op_ski_in, op_sko_in, op_ion_in, op_iof_in, int_ack_in;
    char_t kbd_data_in, ac_low_in, prn_data_out, inpr_out;
    logic kbd_ready_out, prn_valid_out, skip_out, fgi_out, fgo_out, ien_out, irq_out, err_out;
    always #5 clk = ~clk;
    io_unit dut (
        .clk_in(clk), .reset_in(reset_in),
        .kbd_data_in(kbd_data_in), .kbd_valid_in(kbd_valid_in), .kbd_ready_out(kbd_ready_out),
        .prn_data_out(prn_data_out), .prn_valid_out(prn_valid_out), .prn_ready_in(prn_ready_in),
        .ac_low_in(ac_low_in), .inpr_out(inpr_out),
        .op_inp_in(op_inp_in), .op_out_in(op_out_in), .op_ski_in(op_ski_in), .op_sko_in(op_sko_in),
        .op_ion_in(op_ion_in), .op_iof_in(op_iof_in), .int_ack_in(int_ack_in),
        .skip_out(skip_out), .fgi_out(fgi_out), .fgo_out(fgo_out), .ien_out(ien_out),
        .irq_out(irq_out), .err_out(err_out)
    );
    typedef struct {
        char_t inpr, prn_data;
        logic fgi, fgo, ien, pv, kr, skip, irq, err;
    } exp_t;
    exp_t q[$];
    char_t out_q[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0;
    char_t m_inpr, m_outr;
    logic m_fgi, m_fgo, m_ien, m_pv, m_err;
`ifdef IO_ERROR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic m_reset();
        m_inpr = '0; m_outr = '0; m_fgi = 0; m_fgo = 1; m_ien = 0; m_pv = 0; m_err = 0;
        out_q.delete();
    endtask
    task automatic ops_clear();
        {op_inp_in, op_out_in, op_ski_in, op_sko_in, op_ion_in, op_iof_in, int_ack_in} = '0;
        kbd_valid_in = 0; prn_ready_in = 0;
    endtask
    // expectations for this cycle come from the model; state advances after the edge
    task automatic cycle();
        exp_t x;
        x.inpr = m_inpr; x.prn_data = m_outr; x.fgi = m_fgi; x.fgo = m_fgo; x.ien = m_ien;
        x.pv = m_pv; x.kr = !m_fgi; x.err = m_err;
        x.skip = (op_ski_in && m_fgi) || (op_sko_in && m_fgo);
        x.irq = m_ien && (m_fgi || m_fgo);
        q.push_back(x);
        @(posedge clk);
        if (reset_in) m_reset();
        else begin
            if (ERR_EN && ((op_out_in && !m_fgo) || (op_inp_in && !m_fgi))) m_err = 1;
            if (kbd_valid_in && !m_fgi) begin m_inpr = kbd_data_in; m_fgi = 1; end
            else if (op_inp_in) m_fgi = 0;
            if (op_out_in && m_fgo) begin
                m_outr = ac_low_in; m_fgo = 0; m_pv = 1; out_q.push_back(ac_low_in);
            end else if (m_pv && prn_ready_in) begin m_pv = 0; m_fgo = 1; end
            if (int_ack_in || op_iof_in) m_ien = 0;
            else if (op_ion_in) m_ien = 1;
        end
        #1;
    endtask
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("inpr", inpr_out, e.inpr);
            chk("prn_data", prn_data_out, e.prn_data);
            chk("fgi", fgi_out, e.fgi);
            chk("fgo", fgo_out, e.fgo);
            chk("ien", ien_out, e.ien);
            chk("prn_valid", prn_valid_out, e.pv);
            chk("kbd_ready", kbd_ready_out, e.kr);
            chk("skip", skip_out, e.skip);
            chk("irq", irq_out, e.irq);
            chk("err", err_out, e.err);
        end
        if (!reset_in && prn_valid_out === 1'b1 && prn_ready_in) begin
            if (out_q.size() == 0) chk("prn_extra", prn_data_out, 32'hFFFF_FFFF);
            else chk("prn_char", prn_data_out, out_q.pop_front());
        end
    end
    initial begin
        ops_clear();
        kbd_data_in = '0; ac_low_in = '0; reset_in = 1;
        @(posedge clk); m_reset(); #1;
        cycle();
        reset_in = 0;
        chk("rst_inpr", inpr_out, 8'h00);
        chk("rst_fgo", fgo_out, 1);
        chk("rst_kbd_ready", kbd_ready_out, 1);
        chk("rst_irq", irq_out, 0);
        kbd_valid_in = 1; kbd_data_in = 8'h9A; cycle();
        kbd_data_in = 8'h41; cycle();
        kbd_valid_in = 0;
        chk("kbd_inpr", inpr_out, 8'h9A);
        chk("kbd_busy", kbd_ready_out, 0);
        op_ski_in = 1; cycle(); op_ski_in = 0;
        op_inp_in = 1; cycle(); op_inp_in = 0;
        chk("inp_fgi", fgi_out, 0);
        chk("inp_inpr_hold", inpr_out, 8'h9A);
        op_ski_in = 1; cycle(); op_ski_in = 0;
        op_sko_in = 1; cycle(); op_sko_in = 0;
        ac_low_in = 8'h5C; op_out_in = 1; cycle(); op_out_in = 0;
        repeat (3) cycle();
        chk("out_data", prn_data_out, 8'h5C);
        chk("out_valid_hold", prn_valid_out, 1);
        prn_ready_in = 1; cycle(); prn_ready_in = 0;
        chk("prn_done_fgo", fgo_out, 1);
        op_ion_in = 1; cycle(); op_ion_in = 0;
        kbd_valid_in = 1; kbd_data_in = 8'h33; cycle(); kbd_valid_in = 0;
        chk("irq_on", irq_out, 1);
        int_ack_in = 1; op_ion_in = 1; cycle(); int_ack_in = 0; op_ion_in = 0;
        chk("ack_ien", ien_out, 0);
        chk("ack_irq", irq_out, 0);
        ac_low_in = 8'hAA; op_out_in = 1; cycle();
        ac_low_in = 8'h55; cycle(); op_out_in = 0;
        chk("overrun_outr", prn_data_out, 8'hAA);
        chk("overrun_err", err_out, ERR_EN);
        repeat (2) cycle();
        chk("err_sticky", err_out, ERR_EN);
        for (int i = 0; i < 3000; i++) begin
            reset_in = ($urandom_range(63) == 0);
            kbd_valid_in = $urandom_range(1);
            kbd_data_in = char_t'($urandom);
            ac_low_in = char_t'($urandom);
            prn_ready_in = ($urandom_range(2) == 0);
            op_inp_in = ($urandom_range(5) == 0);
            op_out_in = ($urandom_range(4) == 0);
            op_ski_in = ($urandom_range(5) == 0);
            op_sko_in = ($urandom_range(5) == 0);
            op_ion_in = ($urandom_range(6) == 0);
            op_iof_in = ($urandom_range(9) == 0);
            int_ack_in = ($urandom_range(11) == 0);
            cycle();
        end
        reset_in = 0; ops_clear();
        @(negedge clk); @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
